imem_fetch_ctrl: RTL

- Sequences instruction fetches from the byte-addressed, little-endian instruction memory: owns the PC, issues one 32-bit word read at a time, and buffers returned words in a small FIFO tagged with their PC.
- Sits between the instruction memory and the decode stage.
- Decode consumes instructions through a valid/ready handshake.
- Branch/jump resolution redirects the PC; all stale fetches are flushed.

---
 rtl/imem_fetch_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer that owns the PC, issues one word read at a time and buffers returned words tagged with their PC
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   mem_req, mem_addr           - one-cycle read strobe and 4-byte aligned word address
//   mem_rvalid, mem_rdata       - read response (1+ cycles after mem_req)
//   inst_valid/ready/data/pc    - decode handshake on the buffer head
//   redirect_valid, redirect_pc - load a new PC and flush everything stale
//   misalign_err                - one-cycle pulse when a redirect target had low bits set
module imem_fetch_ctrl #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_issued;
  logic outstanding;
  logic [31:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic room, resp, issue, push, pop, empty;
  // An in-flight read already owns a buffer slot, so issue only when it can land
  assign room = (count + CW'(outstanding)) < CW'(DEPTH);
  // A response with nothing outstanding (e.g. from before a reset) is ignored
  assign resp = mem_rvalid && outstanding;
  assign empty = count == '0;
  assign inst_valid = !empty && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst_data = empty ? '0 : fifo_data[rd_ptr];
  assign inst_pc = empty ? '0 : fifo_pc[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // Redirect blocks issue and turns a pending read into one to be discarded
  always_comb begin
    state_n = state;
    issue = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: state_n = ISSUE;
      ISSUE: if (!redirect_valid && room) begin
        issue = 1'b1;
        state_n = WAIT;
      end
      WAIT: if (redirect_valid) state_n = resp ? ISSUE : DRAIN;
      else if (resp) begin
        push = 1'b1;
        state_n = ISSUE;
      end
      DRAIN: if (resp) state_n = ISSUE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc <= RESET_PC & ~ADDR_W'(3);
      pc_issued <= '0;
      outstanding <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      misalign_err <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      pc <= redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : issue ? pc + ADDR_W'(4) : pc;
      mem_req <= issue;
      mem_addr <= issue ? pc : mem_addr;
      pc_issued <= issue ? pc : pc_issued;
      outstanding <= issue ? 1'b1 : resp ? 1'b0 : outstanding;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr] <= pc_issued;
    end
endmodule
